// File: rtl/layer_scheduler_if.sv
// Handshake and memory-control bundle between a layer sequencer and its
// requester/datapath: start/config in, MAC and SRAM strobes/addresses out.
interface layer_scheduler_if;
    logic        start;
    logic [7:0]  cfg_n_out;
    logic        busy;
    logic        done;
    logic [3:0]  in_addr;
    logic [11:0] w_addr;
    logic        mac_clr;
    logic        mac_en;
    logic        mid_we;
    logic [5:0]  mid_bank;
    logic [4:0]  mid_addr;

    modport master (
        output start, cfg_n_out,
        input  busy, done, in_addr, w_addr, mac_clr, mac_en,
               mid_we, mid_bank, mid_addr
    );

    modport slave (
        input  start, cfg_n_out,
        output busy, done, in_addr, w_addr, mac_clr, mac_en,
               mid_we, mid_bank, mid_addr
    );
endinterface

// File: rtl/layer_scheduler.sv
// Sequences one fully-connected layer: per output neuron clear the MAC, stream
// N_IN input/weight rows, drain the MAC pipeline and write the activation.
module layer_scheduler #(
    parameter int N_IN    = 13,
    parameter int MAC_LAT = 1,
    parameter int N_BANK  = 64
) (
    input  logic               clk,
    input  logic               reset,
    layer_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, WRITE, FIN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  n;
    logic [7:0]  n_total;
    logic [3:0]  k;
    logic [7:0]  dcnt;
    logic        last_k, last_d, last_n;
    logic [11:0] w_calc;
    logic [5:0]  bank_calc;
    logic [4:0]  row_calc;
    logic [3:0]  in_addr_hold;
    logic [11:0] w_addr_hold;
    logic [5:0]  bank_hold;
    logic [4:0]  row_hold;
    logic        accum_p1;

    assign last_k    = (k == 4'(N_IN - 1));
    assign last_d    = (dcnt == 8'(MAC_LAT));
    assign last_n    = (n == n_total - 8'd1);
    assign w_calc    = 12'(32'(n) * N_IN + 32'(k));
    assign bank_calc = 6'(32'(n) % N_BANK);
    assign row_calc  = 5'(32'(n) / N_BANK);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.cfg_n_out == 8'd0) ? FIN : CLEAR;
            CLEAR:   state_nxt = ACCUM;
            ACCUM:   if (last_k) state_nxt = DRAIN;
            DRAIN:   if (last_d) state_nxt = WRITE;
            WRITE:   state_nxt = last_n ? FIN : CLEAR;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // k parks on N_IN-1 after the last row so DRAIN/WRITE see a stable count
    always_ff @(posedge clk) begin
        if (reset) begin
            n       <= 8'd0;
            n_total <= 8'd0;
            k       <= 4'd0;
            dcnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    n_total <= bus.cfg_n_out;
                    n       <= 8'd0;
                    k       <= 4'd0;
                end
                ACCUM: begin
                    dcnt <= 8'd0;
                    if (!last_k) k <= k + 4'd1;
                end
                DRAIN: dcnt <= dcnt + 8'd1;
                WRITE: if (!last_n) begin
                    n <= n + 8'd1;
                    k <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    // stage p1: mac_en follows the synchronous SRAM read by one cycle
    always_ff @(posedge clk) begin
        if (reset) accum_p1 <= 1'b0;
        else       accum_p1 <= (state == ACCUM);
    end

    // address outputs hold their last driven value between active states
    always_ff @(posedge clk) begin
        if (reset) begin
            in_addr_hold <= 4'd0;
            w_addr_hold  <= 12'd0;
            bank_hold    <= 6'd0;
            row_hold     <= 5'd0;
        end else begin
            in_addr_hold <= bus.in_addr;
            w_addr_hold  <= bus.w_addr;
            bank_hold    <= bus.mid_bank;
            row_hold     <= bus.mid_addr;
        end
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mac_clr  = 1'b0;
        bus.mid_we   = 1'b0;
        bus.mac_en   = accum_p1;
        bus.in_addr  = in_addr_hold;
        bus.w_addr   = w_addr_hold;
        bus.mid_bank = bank_hold;
        bus.mid_addr = row_hold;
        case (state)
            CLEAR: begin
                bus.busy    = 1'b1;
                bus.mac_clr = 1'b1;
            end
            ACCUM: begin
                bus.busy    = 1'b1;
                bus.in_addr = k;
                bus.w_addr  = w_calc;
            end
            DRAIN: bus.busy = 1'b1;
            WRITE: begin
                bus.busy     = 1'b1;
                bus.mid_we   = 1'b1;
                bus.mid_bank = bank_calc;
                bus.mid_addr = row_calc;
            end
            FIN:     bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: cycle-by-cycle phase model plus
// hand-computed layer totals (write counts, done cycle, last bank/row).
module tb_layer_scheduler;

    localparam int NI  = 13;
    localparam int ML  = 1;
    localparam int PER = 3 + NI + ML;

    logic clk;
    logic reset;

    layer_scheduler_if bus ();

    layer_scheduler #(.N_IN(NI), .MAC_LAT(ML), .N_BANK(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_c    = 0;
    int we_cnt, first_we, last_we, done_seen, last_bank, last_row;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cur_c, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_accum(input int cc, input int cfg);
        int p;
        if (cc < 1) return 1'b0;
        if ((cc - 1) / PER >= cfg) return 1'b0;
        p = (cc - 1) % PER;
        return (p >= 1) && (p <= NI);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    bus.busy,     0);
        check({tag, "_done"},    bus.done,     0);
        check({tag, "_mac_clr"}, bus.mac_clr,  0);
        check({tag, "_mac_en"},  bus.mac_en,   0);
        check({tag, "_mid_we"},  bus.mid_we,   0);
        check({tag, "_in_addr"}, bus.in_addr,  0);
        check({tag, "_w_addr"},  bus.w_addr,   0);
        check({tag, "_bank"},    bus.mid_bank, 0);
        check({tag, "_row"},     bus.mid_addr, 0);
    endtask

    // Start a layer in the current cycle (cycle 0) and check every cycle up
    // to done plus one; optionally pulse start mid-layer or abort with reset.
    task automatic observe(input int cfg, input int pulse_c, input int pulse_cfg, input int abort_c);
        int done_c, j, p, ia, wa;
        bit act;
        cur_c = 0;
        bus.start     = 1'b1;
        bus.cfg_n_out = cfg[7:0];
        done_c    = (cfg == 0) ? 1 : cfg * PER + 1;
        we_cnt    = 0;
        first_we  = -1;
        last_we   = -1;
        done_seen = -1;
        last_bank = -1;
        last_row  = -1;
        for (int c = 1; c <= done_c; c++) begin
            step();
            cur_c     = c;
            bus.start = 1'b0;
            j   = (c - 1) / PER;
            p   = (c - 1) % PER;
            act = (c < done_c);
            check("busy",    bus.busy,    act);
            check("done",    bus.done,    c == done_c);
            check("mac_clr", bus.mac_clr, act && p == 0);
            check("mid_we",  bus.mid_we,  act && p == PER - 1);
            check("mac_en",  bus.mac_en,  c >= 2 && in_accum(c - 1, cfg));
            if (act && (p >= 1 || j > 0)) begin
                if (p >= 1 && p <= NI) begin
                    ia = p - 1;
                    wa = j * NI + p - 1;
                end else if (p == 0) begin
                    ia = NI - 1;
                    wa = (j - 1) * NI + NI - 1;
                end else begin
                    ia = NI - 1;
                    wa = j * NI + NI - 1;
                end
                check("in_addr", bus.in_addr, ia);
                check("w_addr",  bus.w_addr,  wa);
            end
            if (act && p == PER - 1) begin
                check("mid_bank", bus.mid_bank, j % 64);
                check("mid_addr", bus.mid_addr, j / 64);
            end else if (act && j > 0) begin
                check("bank_hold", bus.mid_bank, (j - 1) % 64);
                check("row_hold",  bus.mid_addr, (j - 1) / 64);
            end else if (c == done_c && cfg > 0) begin
                check("bank_fin", bus.mid_bank, (cfg - 1) % 64);
                check("row_fin",  bus.mid_addr, (cfg - 1) / 64);
            end
            if (bus.mid_we) begin
                we_cnt++;
                if (first_we < 0) first_we = c;
                last_we   = c;
                last_bank = int'(bus.mid_bank);
                last_row  = int'(bus.mid_addr);
            end
            if (bus.done && done_seen < 0) done_seen = c;
            if (c == pulse_c) begin
                bus.start     = 1'b1;
                bus.cfg_n_out = pulse_cfg[7:0];
            end
            if (c == abort_c) begin
                reset = 1'b1;
                step();
                cur_c++;
                check_all_zero("abort");
                reset = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    step();
                    cur_c++;
                    check("abort_done",   bus.done,   0);
                    check("abort_mid_we", bus.mid_we, 0);
                    check("abort_busy",   bus.busy,   0);
                end
                return;
            end
        end
        step();
        cur_c++;
        check("post_done", bus.done, 0);
        check("post_busy", bus.busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_n_out = 8'd0;
        step();
        step();
        step();
        check_all_zero("reset");

        // reset wins over a simultaneous start
        bus.start     = 1'b1;
        bus.cfg_n_out = 8'd5;
        step();
        bus.start = 1'b0;
        check("rst_prio_busy", bus.busy, 0);
        check("rst_prio_clr",  bus.mac_clr, 0);
        reset = 1'b0;
        step();
        check("rst_prio_idle", bus.busy, 0);

        observe(2, 0, 0, 0);
        check("n2_we_cnt",   we_cnt,    2);
        check("n2_first_we", first_we,  17);
        check("n2_last_we",  last_we,   34);
        check("n2_done",     done_seen, 35);
        check("n2_bank",     last_bank, 1);
        check("n2_row",      last_row,  0);

        observe(0, 0, 0, 0);
        check("n0_we_cnt", we_cnt,    0);
        check("n0_done",   done_seen, 1);

        observe(3, 5, 9, 0);
        check("ign_we_cnt", we_cnt,    3);
        check("ign_done",   done_seen, 52);

        observe(200, 0, 0, 0);
        check("n200_we_cnt", we_cnt,    200);
        check("n200_bank",   last_bank, 7);
        check("n200_row",    last_row,  3);
        check("n200_done",   done_seen, 3401);

        observe(10, 0, 0, 90);
        check("abort_we_cnt", we_cnt,    5);
        check("abort_nodone", done_seen, -1);

        observe(2, 0, 0, 0);
        check("rerun_we_cnt", we_cnt,    2);
        check("rerun_done",   done_seen, 35);
        check("rerun_bank",   last_bank, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter N_IN, default 13: input SRAM rows consumed per output neuron.
REQ-002 SHALL have parameter MAC_LAT, default 1: MAC pipeline cycles from mac_en to a valid psum.
REQ-003 SHALL have parameter N_BANK, default 64: number of intermediate SRAM banks.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to run one layer.
REQ-007 SHALL have port cfg_n_out, input, 8: number of output neurons, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1: high while the layer is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the layer completes.
REQ-010 SHALL have port in_addr, output, 4: input SRAM row address.
REQ-011 SHALL have port w_addr, output, 12: weight SRAM address.
REQ-012 SHALL have port mac_clr, output, 1: clears the MAC accumulator.
REQ-013 SHALL have port mac_en, output, 1: MAC accumulate enable.
REQ-014 SHALL have port mid_we, output, 1: intermediate SRAM write strobe for the activation output.
REQ-015 SHALL have port mid_bank, output, 6: intermediate SRAM bank select.
REQ-016 SHALL have port mid_addr, output, 5: intermediate SRAM row address.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, ACCUM, DRAIN, WRITE and FIN.
REQ-018 SHALL, in IDLE with start=1, latch cfg_n_out, zero the neuron counter n and the row counter k, and go to CLEAR the next cycle; if cfg_n_out=0 it SHALL go to FIN instead.
REQ-019 SHALL ignore start in every state other than IDLE, with no effect on the latched cfg_n_out.
REQ-020 SHALL assert mac_clr for exactly the one cycle spent in CLEAR, then go to ACCUM.
REQ-021 SHALL spend exactly N_IN cycles in ACCUM, driving in_addr=k and w_addr=n*N_IN+k (12-bit, no saturation), with k stepping 0..N_IN-1.
REQ-022 SHALL register mac_en as state==ACCUM delayed one cycle, to match the one-cycle synchronous SRAM read; mac_en SHALL be high for exactly N_IN consecutive cycles per neuron.
REQ-023 SHALL spend exactly 1+MAC_LAT cycles in DRAIN, then go to WRITE.
REQ-024 SHALL assert mid_we for the one cycle in WRITE, with mid_bank=n mod N_BANK and mid_addr=n div N_BANK.
REQ-025 SHALL, on leaving WRITE, go to FIN if n=cfg_n_out-1; otherwise it SHALL increment n, reset k to 0 and go to CLEAR.
REQ-026 SHALL assert done for the single cycle in FIN, then return to IDLE.
REQ-027 SHALL drive busy high in CLEAR, ACCUM, DRAIN and WRITE, and low in IDLE and FIN.
REQ-028 SHALL take 3+N_IN+MAC_LAT cycles per neuron: 17 at the defaults.
REQ-029 SHALL accept a start arriving in the cycle right after done, with no dead cycle required.
REQ-030 SHALL hold in_addr, w_addr, mid_bank and mid_addr at their last values outside the states that drive them.
REQ-031 SHALL keep mac_clr, mac_en and mid_we low outside their defined cycles.
REQ-032 SHALL wrap mid_bank from N_BANK-1 to 0 while mid_addr increments: neuron 64 maps to bank 0, row 1.

Reset
REQ-033 SHALL, whenever reset=1 at a clock edge, force state IDLE and clear n, k and the latched cfg_n_out.
REQ-034 SHALL, on reset, drive busy, done, mac_clr, mac_en and mid_we to 0 and in_addr, w_addr, mid_bank and mid_addr to 0.
REQ-035 SHALL let reset take priority over start in the same cycle.
REQ-036 SHALL, when reset arrives mid-layer, abort the layer with no further mid_we and no done pulse.

Verification
REQ-037 SHALL cover: start at cycle 0 with cfg_n_out=2 -> busy high from cycle 1, mid_we at cycles 17 and 34 (bank 0/row 0, then bank 1/row 0), done at cycle 35.
REQ-038 SHALL cover: neuron 1 -> w_addr steps 13..25 while in_addr steps 0..12; mac_en lags the addresses by exactly 1 cycle.
REQ-039 SHALL cover: cfg_n_out=0 -> done pulses 1 cycle after start, with no mac_clr, mac_en or mid_we.
REQ-040 SHALL cover: cfg_n_out=200 -> 200 writes, the last to bank 7/row 3, and done at cycle 3401.
REQ-041 SHALL cover: reset during ACCUM of neuron 5 -> all outputs 0 on the next cycle, no done; a new start then runs normally from neuron 0.
REQ-042 SHALL cover: start pulsed while busy, with a different cfg_n_out -> ignored; the original write count and done timing are unchanged.
